matrix_stream_loader: RTL and testbench

//  Upstream of the matrix negation and arithmetic stages. Receives signed 8-bit elements one at a

---
 rtl/matrix_pkg.sv | 14 +
 rtl/matrix_stream_loader_if.sv | 22 ++
 rtl/matrix_size_decoder.sv | 9 +
 rtl/matrix_stream_loader.sv | 70 +++++++
 tb/tb_matrix_stream_loader.sv | 212 +++++++++++++++++++++
 5 files changed

// File: rtl/matrix_pkg.sv
// matrix_pkg: shared widths, size codes, load states and element-count helper for the matrix stages
package matrix_pkg;
  localparam int ELEM_W = 8;
  localparam int MAX_ELEMS = 25;
  localparam int MAT_BUS_W = ELEM_W * MAX_ELEMS;
  localparam logic [1:0] SZ_2X2 = 2'b00;
  localparam logic [1:0] SZ_3X3 = 2'b01;
  localparam logic [1:0] SZ_4X4 = 2'b10;
  localparam logic [1:0] SZ_5X5 = 2'b11;
  typedef enum logic [1:0] {IDLE, LOAD, FULL} load_state_e;
  function automatic logic [4:0] active_elems(input logic [1:0] size);
    return size == SZ_2X2 ? 5'd4 : size == SZ_3X3 ? 5'd9 : size == SZ_4X4 ? 5'd16 : 5'd25;
  endfunction
endpackage

// File: rtl/matrix_stream_loader_if.sv
// matrix_stream_loader_if: element stream in, packed matrix out, with producer/loader modports
interface matrix_stream_loader_if;
  import matrix_pkg::*;
  logic                 start;
  logic [1:0]           matrix_size;
  logic [ELEM_W-1:0]    elem_in;
  logic                 elem_valid;
  logic                 elem_ready;
  logic [MAT_BUS_W-1:0] matrix_A;
  logic [1:0]           matrix_size_out;
  logic                 matrix_valid;
  logic                 matrix_ack;
  logic                 busy;
  modport master (
    output start, matrix_size, elem_in, elem_valid, matrix_ack,
    input  elem_ready, matrix_A, matrix_size_out, matrix_valid, busy
  );
  modport slave (
    input  start, matrix_size, elem_in, elem_valid, matrix_ack,
    output elem_ready, matrix_A, matrix_size_out, matrix_valid, busy
  );
endinterface

// File: rtl/matrix_size_decoder.sv
// matrix_size_decoder: size code to active element count, shared by all matrix stages
module matrix_size_decoder
  import matrix_pkg::*;
(
  input  logic [1:0] size_i,
  output logic [4:0] n_o
);
  assign n_o = active_elems(size_i);
endmodule

// File: rtl/matrix_stream_loader.sv
// matrix_stream_loader: packs a streamed signed element sequence row-major into the matrix bus (LOADER_CLEAR_EN zeroes the bus on start)
module matrix_stream_loader
  import matrix_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  matrix_stream_loader_if.slave bus
);
  load_state_e          state_q, state_d;
  logic [4:0]           count_q, count_d, n_q, n_d, dec_n;
  logic [1:0]           size_q, size_d;
  logic [MAT_BUS_W-1:0] mat_q, mat_d;
  logic                 valid_q, valid_d, ready_q, ready_d, busy_q, busy_d;
  matrix_size_decoder u_dec (.size_i(bus.matrix_size), .n_o(dec_n));
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      count_q <= '0;
      n_q     <= '0;
      size_q  <= SZ_2X2;
      mat_q   <= '0;
      valid_q <= 1'b0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      n_q     <= n_d;
      size_q  <= size_d;
      mat_q   <= mat_d;
      valid_q <= valid_d;
      ready_q <= ready_d;
      busy_q  <= busy_d;
    end
  end
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    n_d     = n_q;
    size_d  = size_q;
    mat_d   = mat_q;
    case (state_q)
      IDLE: if (bus.start) begin
        state_d = LOAD;
        size_d  = bus.matrix_size;
        count_d = '0;
        n_d     = dec_n;
`ifdef LOADER_CLEAR_EN
        mat_d   = '0;
`endif
      end
      LOAD: if (bus.elem_valid && ready_q) begin
        mat_d[int'(count_q)*ELEM_W +: ELEM_W] = bus.elem_in;
        count_d = count_q + 5'd1;
        state_d = count_q == n_q - 5'd1 ? FULL : LOAD;
      end
      FULL: state_d = valid_q && bus.matrix_ack ? IDLE : FULL;
      default: state_d = IDLE;
    endcase
    // valid trails entry into FULL by one edge, so ack is only honoured once valid is visible
    valid_d = state_q == FULL && state_d == FULL;
    ready_d = state_d == LOAD;
    busy_d  = state_d != IDLE;
  end
  assign bus.elem_ready      = ready_q;
  assign bus.matrix_A        = mat_q;
  assign bus.matrix_size_out = size_q;
  assign bus.matrix_valid    = valid_q;
  assign bus.busy            = busy_q;
endmodule

// File: tb/tb_matrix_stream_loader.sv
// tb_matrix_stream_loader: directed loads with a scoreboard monitor checking each presented matrix
module tb_matrix_stream_loader;
  import matrix_pkg::*;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  matrix_stream_loader_if bus();
  matrix_stream_loader dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`ifdef LOADER_CLEAR_EN
  localparam logic [7:0] STALE = 8'h00;
`else
  localparam logic [7:0] STALE = 8'h7F;
`endif
  typedef struct packed {logic [MAT_BUS_W-1:0] mat; logic [1:0] sz;} exp_t;
  exp_t sb[$];
  int n_checks = 0;
  int n_fail = 0;
  logic [MAT_BUS_W-1:0] exp_mat = '0;
  logic [1:0] exp_sz = 2'b00;
  int exp_n = 0;
  int exp_idx = 0;
  logic prev_valid = 1'b0;
  task automatic check(input string name, input logic [MAT_BUS_W-1:0] got, input logic [MAT_BUS_W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask
  always @(negedge clk) begin
    if (rst_n && bus.matrix_valid && !prev_valid) begin
      if (sb.size() == 0) check("unexpected_matrix", 1, 0);
      else begin
        check("sb_matrix_A", bus.matrix_A, sb[0].mat);
        check("sb_size", MAT_BUS_W'(bus.matrix_size_out), MAT_BUS_W'(sb[0].sz));
        void'(sb.pop_front());
      end
    end
    prev_valid <= rst_n && bus.matrix_valid;
  end
  task automatic begin_load(input logic [1:0] sz);
    bus.start = 1'b1;
    bus.matrix_size = sz;
    exp_sz = sz;
    exp_n = sz == 2'd0 ? 4 : sz == 2'd1 ? 9 : sz == 2'd2 ? 16 : 25;
    exp_idx = 0;
`ifdef LOADER_CLEAR_EN
    exp_mat = '0;
`endif
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask
  task automatic send(input logic [7:0] e, input int gap);
    logic acc = 1'b0;
    bus.elem_in = e;
    bus.elem_valid = 1'b1;
    for (int t = 0; t < 50 && !acc; t++) begin
      @(negedge clk) acc = bus.elem_ready;
      @(posedge clk);
      #1;
    end
    bus.elem_valid = 1'b0;
    if (!acc) check("accept_timeout", 0, 1);
    exp_mat[exp_idx*8 +: 8] = e;
    exp_idx++;
    if (exp_idx == exp_n) sb.push_back({exp_mat, exp_sz});
    repeat (gap) begin
      @(posedge clk);
      #1;
    end
  endtask
  task automatic wait_valid(input string name);
    int t = 0;
    @(negedge clk);
    while (!bus.matrix_valid && t < 60) begin
      @(negedge clk);
      t++;
    end
    check(name, bus.matrix_valid, 1);
  endtask
  task automatic do_ack();
    bus.matrix_ack = 1'b1;
    @(posedge clk);
    #1 bus.matrix_ack = 1'b0;
    @(negedge clk);
    check("ack_valid_low", bus.matrix_valid, 0);
    check("ack_busy_low", bus.busy, 0);
    @(posedge clk);
    #1;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
  initial begin
    bus.start = 1'b0;
    bus.matrix_size = 2'b00;
    bus.elem_in = '0;
    bus.elem_valid = 1'b0;
    bus.matrix_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_valid", bus.matrix_valid, 0);
    check("rst_ready", bus.elem_ready, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_matrix_A", bus.matrix_A, 0);
    check("rst_size", bus.matrix_size_out, 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    // T1: 2x2 back-to-back, valid 6 edges counting the start edge as the first
    begin_load(2'b00);
    check("t1_ready_after_start", bus.elem_ready, 1);
    check("t1_busy_after_start", bus.busy, 1);
    send(8'd1, 0);
    send(8'hFE, 0);
    send(8'd3, 0);
    send(8'h80, 0);
    check("t1_ready_drop", bus.elem_ready, 0);
    check("t1_valid_not_yet", bus.matrix_valid, 0);
    check("t1_busy_full", bus.busy, 1);
    @(posedge clk);
    #1;
    check("t1_latency_valid", bus.matrix_valid, 1);
    check("t1_low_slots", bus.matrix_A[31:0], 32'h80_03_FE_01);
    check("t1_size", bus.matrix_size_out, 2'b00);
    @(negedge clk);
    do_ack();
    // T2: 5x5 with gaps between elements, valid held until ack
    begin_load(2'b11);
    for (int k = 0; k < 25; k++) send(8'(k), 1);
    check("t2_ready_low", bus.elem_ready, 0);
    wait_valid("t2_valid");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_valid_held", bus.matrix_valid, 1);
    end
    check("t2_slot24", bus.matrix_A[199:192], 8'd24);
    check("t2_slot13", bus.matrix_A[111:104], 8'd13);
    check("t2_size", bus.matrix_size_out, 2'b11);
    do_ack();
    // T3: start during LOAD is ignored
    begin_load(2'b01);
    for (int k = 0; k < 3; k++) send(8'(10 + k), 0);
    bus.start = 1'b1;
    bus.matrix_size = 2'b11;
    @(posedge clk);
    #1 bus.start = 1'b0;
    check("t3_still_loading", bus.elem_ready, 1);
    for (int k = 3; k < 9; k++) send(8'(10 + k), 0);
    wait_valid("t3_valid");
    check("t3_size", bus.matrix_size_out, 2'b01);
    do_ack();
    // T4: reset mid-load, then a fresh 2x2
    begin_load(2'b10);
    send(8'd21, 0);
    send(8'd22, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    check("t4_rst_matrix_A", bus.matrix_A, 0);
    check("t4_rst_size", bus.matrix_size_out, 0);
    check("t4_rst_valid", bus.matrix_valid, 0);
    check("t4_rst_ready", bus.elem_ready, 0);
    check("t4_rst_busy", bus.busy, 0);
    exp_mat = '0;
    rst_n = 1'b1;
    begin_load(2'b00);
    for (int k = 0; k < 4; k++) send(8'(k + 40), 0);
    wait_valid("t4_valid");
    check("t4_slot3", bus.matrix_A[31:24], 8'd43);
    do_ack();
    // T5: stale slots above N after a smaller reload
    begin_load(2'b11);
    for (int k = 0; k < 25; k++) send(8'h7F, 0);
    wait_valid("t5_valid_5x5");
    do_ack();
    begin_load(2'b00);
    for (int k = 0; k < 4; k++) send(8'h01, 0);
    wait_valid("t5_valid_2x2");
    check("t5_slot0", bus.matrix_A[7:0], 8'h01);
    for (int s = 4; s < 25; s++) check($sformatf("t5_slot%0d", s), bus.matrix_A[s*8 +: 8], STALE);
    do_ack();
    // T6: ack and start together in FULL -> IDLE, start ignored
    begin_load(2'b00);
    for (int k = 5; k < 9; k++) send(8'(k), 0);
    wait_valid("t6_valid");
    bus.matrix_ack = 1'b1;
    bus.start = 1'b1;
    bus.matrix_size = 2'b10;
    @(posedge clk);
    #1;
    bus.matrix_ack = 1'b0;
    bus.start = 1'b0;
    check("t6_valid_low", bus.matrix_valid, 0);
    check("t6_busy_low", bus.busy, 0);
    check("t6_ready_low", bus.elem_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("t6_still_idle", bus.busy, 0);
    begin_load(2'b01);
    check("t6_new_busy", bus.busy, 1);
    for (int k = 0; k < 9; k++) send(8'(8'hF0 + k), 0);
    wait_valid("t6_new_valid");
    check("t6_new_size", bus.matrix_size_out, 2'b01);
    do_ack();
    check("sb_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
